// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
// The flattened tree buses in mux_tree_pipe are laid out level by level;
// the offset helpers below locate each level inside those buses.
package mux_tree_pkg;

    localparam int COUNT_W = 32;

    // Tree depth, never less than one level even for degenerate input counts.
    function automatic int level_count(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Word offset of level k inside the flattened data bus (level 0 = inputs).
    function automatic int word_off(input int n, input int k);
        return 2 * n - 2 * (n >> k);
    endfunction

    // Bit offset of level k inside the flattened select bus; level k carries
    // l-k select bits.
    function automatic int sel_off(input int l, input int k);
        return k * l - (k * (k - 1)) / 2;
    endfunction

    // Width of the select bits a stage passes on; a one-bit pad is used for
    // the last stage, which has nothing left to pass on.
    function automatic int sel_out_w(input int w);
        return (w > 1) ? w - 1 : 1;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: halves the word count using the lowest select
// bit, then registers the surviving words, the remaining select bits and a
// valid flag behind a valid/ready handshake.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int IN_WORDS = 2,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_WORDS*WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]                  in_sel,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [(IN_WORDS/2)*WIDTH-1:0]     out_data,
    output logic [sel_out_w(SEL_W)-1:0]       out_sel,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int OUT_WORDS = IN_WORDS / 2;
    localparam int OSEL_W    = sel_out_w(SEL_W);

    logic [OUT_WORDS*WIDTH-1:0] mux_w;
    logic [OUT_WORDS*WIDTH-1:0] data_q, data_d;
    logic [OSEL_W-1:0]          sel_next;
    logic [OSEL_W-1:0]          sel_q, sel_d;
    logic                       valid_q, valid_d;
    logic                       load;

    // The register may take a new value when it is empty or being drained
    // this cycle; an empty stage therefore fills even behind a stalled one.
    assign load     = !valid_q || out_ready;
    assign in_ready = load;

    // Select bits above the one consumed here travel along with the data.
    generate
        if (SEL_W > 1) begin : g_pass_sel
            assign sel_next = in_sel[SEL_W-1:1];
        end else begin : g_last_sel
            assign sel_next = '0;
        end
    endgenerate

    // Pairwise 2:1 selection: word j = sel[0] ? word(2j+1) : word(2j).
    always_comb begin
        mux_w = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            mux_w[j*WIDTH +: WIDTH] = in_sel[0] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                                : in_data[(2*j)*WIDTH +: WIDTH];
        end
    end

    // Next-state: on load the valid flag follows the upstream valid, and the
    // payload is only refreshed when there is a real transaction to capture.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = mux_w;
                sel_d  = sel_next;
            end
        end
    end

    // Pipeline register with synchronous reset that empties the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Parametrised N:1 multiplexer built as a chain of registered 2:1 levels with
// valid/ready backpressure; latency is one cycle per level.
// Optional accepted-output counter enabled by defining MUX_TREE_PIPE_COUNT_EN;
// without it out_count is constant zero.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int WIDTH  = 8,
    localparam int LEVELS = level_count(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [LEVELS-1:0]     in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_W-1:0]    out_count
);

    // Level k occupies (N_IN >> k) words of the data bus and LEVELS-k bits of
    // the select bus; the final level is a single word with no select bits.
    localparam int DATA_BITS = (2 * N_IN - 1) * WIDTH;
    localparam int SEL_BITS  = (LEVELS * (LEVELS + 1)) / 2;

    wire [DATA_BITS-1:0] tree_data;
    wire [SEL_BITS-1:0]  tree_sel;
    wire [LEVELS:0]      tree_valid;
    wire [LEVELS:0]      tree_ready;
    wire                 sel_unused;

    assign tree_data[N_IN*WIDTH-1:0] = in_data;
    assign tree_sel[LEVELS-1:0]      = in_sel;
    assign tree_valid[0]             = in_valid;
    assign in_ready                  = tree_ready[0];
    assign tree_ready[LEVELS]        = out_ready;
    assign out_valid                 = tree_valid[LEVELS];
    assign out_data                  = tree_data[word_off(N_IN, LEVELS)*WIDTH +: WIDTH];

    generate
        for (genvar k = 0; k < LEVELS; k++) begin : g_level
            if (k < LEVELS - 1) begin : g_mid
                mux_tree_stage #(
                    .IN_WORDS (N_IN >> k),
                    .WIDTH    (WIDTH),
                    .SEL_W    (LEVELS - k)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .in_data   (tree_data[word_off(N_IN, k)*WIDTH +: (N_IN >> k)*WIDTH]),
                    .in_sel    (tree_sel[sel_off(LEVELS, k) +: (LEVELS - k)]),
                    .in_valid  (tree_valid[k]),
                    .in_ready  (tree_ready[k]),
                    .out_data  (tree_data[word_off(N_IN, k+1)*WIDTH +: (N_IN >> (k+1))*WIDTH]),
                    .out_sel   (tree_sel[sel_off(LEVELS, k+1) +: (LEVELS - k - 1)]),
                    .out_valid (tree_valid[k+1]),
                    .out_ready (tree_ready[k+1])
                );
            end else begin : g_last
                mux_tree_stage #(
                    .IN_WORDS (N_IN >> k),
                    .WIDTH    (WIDTH),
                    .SEL_W    (LEVELS - k)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .in_data   (tree_data[word_off(N_IN, k)*WIDTH +: (N_IN >> k)*WIDTH]),
                    .in_sel    (tree_sel[sel_off(LEVELS, k) +: (LEVELS - k)]),
                    .in_valid  (tree_valid[k]),
                    .in_ready  (tree_ready[k]),
                    .out_data  (tree_data[word_off(N_IN, k+1)*WIDTH +: WIDTH]),
                    .out_sel   (sel_unused),
                    .out_valid (tree_valid[k+1]),
                    .out_ready (tree_ready[k+1])
                );
            end
        end
    endgenerate

`ifdef MUX_TREE_PIPE_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Count every word the consumer takes; wraps naturally at full scale.
    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Counter register, cleared with the rest of the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`else
    assign out_count = '0;
`endif

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N:1 multiplexer built as a binary tree of 2:1 select levels, each level followed by a valid/ready pipeline register.
- Successor to the fixed 4:1 structural mux: generalised in input count and data width, with backpressure.
- Sits between multi-source datapaths and a single consumer that can stall.
- One transaction is a full input vector plus a select; exactly one data word reaches the output per accepted transaction.

Parameters:
- N_IN, 4, number of inputs; power of two, >= 2.
- WIDTH, 8, bits per input word.
- LEVELS, $clog2(N_IN), tree depth; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_IN*WIDTH  packed inputs; word i = in_data[i*WIDTH +: WIDTH].
- in_sel  in  LEVELS  select index; bit k steers level k (bit 0 at leaf level).
- in_valid  in  1  transaction offered.
- in_ready  out  1  level 0 can accept.
- out_data  out  WIDTH  selected word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_count  out  32  accepted-output counter (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_count=0. in_ready=1 in the first cycle after reset.
- Level k (0..LEVELS-1):
  - Takes 2^(LEVELS-k) words and sel bits [LEVELS-1:k].
  - Word j of the result = sel[k] ? word(2j+1) : word(2j).
  - Registers the N_IN>>(k+1) resulting words, the remaining sel bits [LEVELS-1:k+1] and a valid bit.
- The last level register drives out_data/out_valid. Latency is LEVELS cycles from in_valid&&in_ready to out_valid, with no stalls.
- Stage handshake:
  - Stage k loads when its valid is 0, or when it is being drained by the next stage / out_ready this cycle.
  - in_ready = stage-0 load condition.
  - Bubbles collapse: an empty stage loads even while a downstream stage is stalled.
- Throughput: one transaction per cycle when out_ready=1 continuously.
- Ordering and data: no reordering, drop or duplication. Data is held stable while out_valid && !out_ready.
- A stage that loads with an invalid input clears its valid bit. Its data register may hold a don't-care, but out_data is only checked when out_valid=1.
- N_IN=2: single level, latency 1.
- sel is captured with the data. Changing in_sel after acceptance has no effect.
- Reset mid-operation: all in-flight transactions are discarded on the next edge, with no output for them.

Optional Feature:
- Macro: MUX_TREE_PIPE_COUNT_EN.
- Defined: out_count increments by 1 on each out_valid&&out_ready, wraps 0xFFFF_FFFF -> 0, and is cleared by rst.
- Undefined: out_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package mux_tree_pkg holds:
  - function clog2-safe level count;
  - localparam COUNT_W = 32.
- Sub-module mux_tree_stage, parametrised by IN_WORDS, WIDTH, SEL_W. It contains one mux level, its data/sel/valid register and the load/ready logic.
- The top generates LEVELS instances and chains their valid/ready signals.

Test Plan:
- N_IN=4, WIDTH=8, in_data={8'hDD,8'hCC,8'hBB,8'hAA}; sel=0,1,2,3 on consecutive cycles with out_ready=1 -> out_data AA,BB,CC,DD on cycles 2,3,4,5, out_valid steady 1.
- Same stream with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full; out_data holds its value; after release all 4 words emerge in order with no loss or duplication.
- Single transaction sel=2, then idle -> exactly one out_valid pulse (with out_ready=1), value CC; in_ready stays 1.
- rst asserted for 1 cycle while 2 transactions are in flight -> next cycle out_valid=0, in_ready=1; no stale word ever appears.
- N_IN=8, WIDTH=16, input i = 16'h1000+i, sweep sel 0..7 with random out_ready -> output sequence 1000..1007 in order, latency 3 when unstalled.
- MUX_TREE_PIPE_COUNT_EN defined, counter preloaded via force to 0xFFFF_FFFE, then 3 transfers -> out_count 0xFFFF_FFFF, 0, 1. Undefined -> out_count always 0.
